// File: rtl/zbt_proc_writer.sv
// Write-side port for ZBT bank 1: queues processed pixel pairs and
// issues them in slots the display read port leaves idle.
module zbt_proc_writer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [35:0]       two_proc_pixs,
  input  logic [18:0]       proc_pix_addr,
  input  logic              in_valid,
  input  logic              rd_req,
  input  logic [18:0]       rd_addr,
  output logic [18:0]       mem_addr,
  output logic              mem_we,
  output logic [35:0]       mem_write_data,
  output logic              mem_data_oe,
  output logic [PTR_W:0]    fifo_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow
);

  localparam int E_W = 19 + 36;
  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] L_SAT = '1;

  logic [E_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic [35:0]      r_d1;
  logic [35:0]      r_d2;
  logic             r_v1;
  logic             r_v2;

  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic             w_drop;
  logic [E_W-1:0]   w_head;
  logic [18:0]      w_head_addr;
  logic [35:0]      w_head_data;

  // Pop is decided from pre-edge occupancy, so a pair pushed this
  // cycle into an empty queue waits at least one cycle.
  assign w_pop       = !rd_req && (r_count != '0);
  assign w_full      = (r_count == L_FULL);
  assign w_push      = in_valid && (!w_full || w_pop);
  assign w_drop      = in_valid && !w_push;
  assign w_head      = r_mem[r_rptr];
  assign w_head_addr = w_head[E_W-1:36];
  assign w_head_data = w_head[35:0];

  assign fifo_count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {proc_pix_addr, two_proc_pixs};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (drop_count != L_SAT) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      mem_we   <= 1'b0;
    end else begin
      mem_we <= w_pop;
      if (rd_req) begin
        mem_addr <= rd_addr;
      end else if (w_pop) begin
        mem_addr <= w_head_addr;
      end
    end
  end

  // Data trails its address by two cycles on the ZBT write pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d1           <= '0;
      r_d2           <= '0;
      r_v1           <= 1'b0;
      r_v2           <= 1'b0;
      mem_write_data <= '0;
      mem_data_oe    <= 1'b0;
    end else begin
      r_v1        <= w_pop;
      r_v2        <= r_v1;
      mem_data_oe <= r_v2;
      if (w_pop) begin
        r_d1 <= w_head_data;
      end
      if (r_v1) begin
        r_d2 <= r_d1;
      end
      if (r_v2) begin
        mem_write_data <= r_d2;
      end
    end
  end

endmodule

// File: tb/tb_zbt_proc_writer.sv
// Randomized and directed bench for zbt_proc_writer against a
// queue-based model of the write port.
module tb_zbt_proc_writer;

  logic        clk;
  logic        reset;
  logic [35:0] two_proc_pixs;
  logic [18:0] proc_pix_addr;
  logic        in_valid;
  logic        rd_req;
  logic [18:0] rd_addr;

  logic [18:0] mem_addr;
  logic        mem_we;
  logic [35:0] mem_write_data;
  logic        mem_data_oe;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;
  logic        overflow;

  logic [18:0] s_mem_addr;
  logic        s_mem_we;
  logic [35:0] s_mem_write_data;
  logic        s_mem_data_oe;
  logic [3:0]  s_fifo_count;
  logic [3:0]  s_drop_count;
  logic        s_overflow;

  zbt_proc_writer u_dut (
    .clk(clk), .reset(reset),
    .two_proc_pixs(two_proc_pixs), .proc_pix_addr(proc_pix_addr),
    .in_valid(in_valid), .rd_req(rd_req), .rd_addr(rd_addr),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_write_data(mem_write_data), .mem_data_oe(mem_data_oe),
    .fifo_count(fifo_count), .drop_count(drop_count),
    .overflow(overflow)
  );

  zbt_proc_writer #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .two_proc_pixs(two_proc_pixs), .proc_pix_addr(proc_pix_addr),
    .in_valid(in_valid), .rd_req(rd_req), .rd_addr(rd_addr),
    .mem_addr(s_mem_addr), .mem_we(s_mem_we),
    .mem_write_data(s_mem_write_data), .mem_data_oe(s_mem_data_oe),
    .fifo_count(s_fifo_count), .drop_count(s_drop_count),
    .overflow(s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] a;
    logic [35:0] d;
  } ent_t;

  typedef struct {
    int          due;
    logic [35:0] d;
  } wr_t;

  ent_t        q[$];
  wr_t         wq[$];
  int          cyc;
  int          m_drops;
  logic        m_ovf;
  logic [18:0] m_addr;
  logic        m_we;
  logic [35:0] m_wd;
  logic        m_oe;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wq.delete();
    m_drops = 0;
    m_ovf   = 1'b0;
    m_addr  = '0;
    m_we    = 1'b0;
    m_wd    = '0;
    m_oe    = 1'b0;
  endtask

  task automatic model_edge();
    logic pop;
    ent_t e;
    ent_t h;
    cyc++;
    pop = !rd_req && (q.size() > 0);
    h   = '{a: '0, d: '0};
    if (pop) begin
      h = q.pop_front();
      wq.push_back('{due: cyc + 2, d: h.d});
    end
    if (in_valid) begin
      if (q.size() < 8) begin
        e.a = proc_pix_addr;
        e.d = two_proc_pixs;
        q.push_back(e);
      end else begin
        m_drops++;
        m_ovf = 1'b1;
      end
    end
    m_we = pop;
    if (rd_req) m_addr = rd_addr;
    else if (pop) m_addr = h.a;
    m_oe = 1'b0;
    if (wq.size() > 0 && wq[0].due == cyc) begin
      m_oe = 1'b1;
      m_wd = wq[0].d;
      void'(wq.pop_front());
    end
  endtask

  task automatic compare();
    int sat;
    sat = (m_drops > 15) ? 15 : m_drops;
    chk("mem_we", 64'(mem_we), 64'(m_we));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_data_oe", 64'(mem_data_oe), 64'(m_oe));
    chk("mem_write_data", 64'(mem_write_data), 64'(m_wd));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("drop_count", 64'(drop_count),
        64'((m_drops > 65535) ? 65535 : m_drops));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count_sat", 64'(s_drop_count), 64'(sat));
  endtask

  task automatic step(input logic iv, input logic [35:0] px,
                      input logic [18:0] ad, input logic rq,
                      input logic [18:0] ra);
    in_valid      = iv;
    two_proc_pixs = px;
    proc_pix_addr = ad;
    rd_req        = rq;
    rd_addr       = ra;
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    compare();
  endtask

  function automatic logic [35:0] rnd36();
    return {4'($urandom), $urandom};
  endfunction

  initial begin
    n_vec         = 0;
    n_err         = 0;
    cyc           = 0;
    reset         = 1'b0;
    in_valid      = 1'b0;
    rd_req        = 1'b0;
    rd_addr       = '0;
    two_proc_pixs = '0;
    proc_pix_addr = '0;
    model_reset();
    #3;
    do_reset();

    // single write
    step(1'b1, 36'h123456789, 19'h00010, 1'b0, '0);
    idle(5);
    chk("single_data", 64'(mem_write_data), 64'h123456789);

    // reads hold the slot while three pairs queue up
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b1, rnd36(), 19'(i + 1), 1'b1, 19'h7FFFF);
      else       step(1'b0, '0, '0, 1'b1, 19'h7FFFF);
    end
    chk("prio_count", 64'(fifo_count), 64'd3);
    idle(6);

    // overflow: ten pushes into eight slots
    for (int i = 0; i < 10; i++)
      step(1'b1, rnd36(), 19'(19'h100 + i), 1'b1, 19'h0ABCD);
    chk("ovf_count", 64'(fifo_count), 64'd8);
    chk("ovf_drops", 64'(drop_count), 64'd2);
    idle(12);

    // full queue with pop and push every cycle
    for (int i = 0; i < 8; i++)
      step(1'b1, rnd36(), 19'(19'h200 + i), 1'b1, 19'h00001);
    for (int i = 8; i < 28; i++)
      step(1'b1, rnd36(), 19'(19'h200 + i), 1'b0, '0);
    chk("full_drops", 64'(drop_count), 64'd2);
    idle(12);

    // reset one cycle after a write issues
    step(1'b1, rnd36(), 19'h33333, 1'b0, '0);
    step(1'b1, rnd36(), 19'h33334, 1'b0, '0);
    step(1'b1, rnd36(), 19'h33335, 1'b0, '0);
    #2;
    do_reset();
    idle(5);

    // drop counter saturation on the narrow instance
    for (int i = 0; i < 28; i++)
      step(1'b1, rnd36(), 19'(i), 1'b1, 19'h12345);
    chk("sat_drops", 64'(s_drop_count), 64'd15);
    idle(12);

    // random traffic with bursty read claims
    for (int b = 0; b < 8; b++) begin
      int rp;
      rp = (b % 2 == 0) ? 8 : 2;
      for (int i = 0; i < 50; i++)
        step($urandom_range(0, 9) < 7, rnd36(), 19'($urandom),
             $urandom_range(0, 9) < rp, 19'($urandom));
    end
    idle(14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/zbt_proc_writer.md
Name: zbt_proc_writer

Overview:
- Stage directly downstream of the edge-processing block.
- Accepts processed pixel pairs (36 bits: two 18-bit pixels) with their 19-bit ZBT bank 1 word address and queues them in a small FIFO.
- Issues ZBT bank 1 write cycles in slots not claimed by the display read port.
- Drives the ZBT 2-cycle write pipeline: address and write-enable first, data two cycles later.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- PTR_W, 3, log2(DEPTH).
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- two_proc_pixs  in  36  processed pixel pair; [35:18] is the first pixel, [17:0] the second.
- proc_pix_addr  in  19  ZBT bank 1 word address for the pair.
- in_valid  in  1  pair/address valid this cycle; no back-pressure upstream.
- rd_req  in  1  display read claims the memory slot this cycle.
- rd_addr  in  19  display read address.
- mem_addr  out  19  registered ZBT address.
- mem_we  out  1  registered write enable, active-high; pad inversion is done elsewhere.
- mem_write_data  out  36  registered write data.
- mem_data_oe  out  1  data bus drive enable, aligned with mem_write_data.
- fifo_count  out  PTR_W+1  current occupancy.
- drop_count  out  CNT_W  number of pairs lost to overflow; saturates.
- overflow  out  1  sticky flag: at least one pair dropped since reset.

Behaviour:
- Reset (asynchronous, active-high) clears all registers immediately:
  - mem_addr=0, mem_we=0, mem_write_data=0, mem_data_oe=0.
  - fifo_count=0, drop_count=0, overflow=0.
  - FIFO pointers=0; the write-data pipeline is flushed.
- Reset asserted mid-operation discards every queued and in-flight write. No mem_data_oe pulse may follow the reset.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - Occupancy is held separately, so full and empty are unambiguous.
- Push, on each rising edge with in_valid=1:
  - Entry {proc_pix_addr, two_proc_pixs} is written if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the pair is dropped: drop_count increments (holding at 2^CNT_W-1) and overflow sets.
- Slot arbitration, evaluated each cycle from current state:
  - rd_req=1: mem_addr<=rd_addr, mem_we<=0. No pop. Reads always win.
  - rd_req=0 and count>0: pop the head entry. mem_addr<=entry address, mem_we<=1. The entry data enters a 2-stage data pipeline.
  - rd_req=0 and count==0: mem_we<=0; mem_addr holds its previous value.
- Simultaneous push and pop: count is unchanged. With an empty FIFO, the same-cycle pop is not allowed, because the pushed entry is not yet visible. The minimum FIFO residency is one cycle.
- Latency:
  - A pair accepted at edge N, with the FIFO empty and rd_req=0 in cycle N+1, produces mem_we=1 with its address after edge N+1.
  - mem_write_data and mem_data_oe=1 appear after edge N+3, exactly 2 cycles after mem_we.
- mem_data_oe is high for exactly one cycle per issued write. Back-to-back writes give continuous mem_data_oe. mem_write_data holds its last value when mem_data_oe=0.
- Ordering: writes issue in strict FIFO order. No coalescing of repeated addresses.
- fifo_count reflects post-edge occupancy.

Test Plan:
- Single write: reset, then in_valid for 1 cycle with addr=0x00010, data=0x123456789, rd_req=0 -> mem_we=1 and mem_addr=0x00010 one cycle later; mem_write_data=0x123456789 with mem_data_oe=1 two cycles after that; fifo_count returns to 0.
- Read priority: queue 3 pairs (addr 1,2,3) while rd_req=1 for 5 cycles with rd_addr=0x7FFFF -> mem_addr=0x7FFFF and mem_we=0 throughout; fifo_count=3. Then rd_req=0 -> writes to 1, 2, 3 on consecutive cycles; data follows 2 cycles behind each.
- Overflow: hold rd_req=1 and push 10 pairs with DEPTH=8 -> fifo_count=8, drop_count=2, overflow=1. Then release rd_req -> exactly the first 8 addresses are written, in order.
- Full with simultaneous pop: fill to 8 with rd_req=1, then rd_req=0 with in_valid=1 for 20 cycles -> no drops; fifo_count stays 8; pointers wrap cleanly; address sequence is contiguous.
- Reset mid-flight: assert reset one cycle after a mem_we=1 -> all outputs 0 immediately; no mem_data_oe pulse afterward; fifo_count=0.
- Saturation: with CNT_W=4, force 20 drops -> drop_count holds at 15.
